// File: rtl/ps2_tx.sv
// ============================================================================
// Module      : ps2_tx
// Description : PS/2 host-to-device byte transmitter with open-drain line
//               enables, device ack check and transfer timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_END  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        INHIBIT      = 3'd1,
        REQUEST      = 3'd2,
        SHIFT        = 3'd3,
        ACK          = 3'd4,
        WAIT_RELEASE = 3'd5
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       bit_idx_q;
    logic [9:0]       frame_q;
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic             clk_oe_q, data_oe_q;
    logic             done_q, error_q;
    logic             fall_d;
    logic             timeout_d;

    assign cnt_d     = cnt_q + CNT_W'(1);
    assign fall_d    = clk_prev_q & ~clk_sync_q;
    assign timeout_d = (cnt_q == TIMEOUT_LAST);

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            frame_q     <= '0;
            // Idle bus level is high, so sync flops start high to avoid a false edge
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            done_q      <= 1'b0;
            error_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        frame_q   <= {1'b1, ~^tx_data, tx_data};
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == INHIBIT_LAST) begin
                        data_oe_q <= 1'b1;
                    end else if (cnt_q == INHIBIT_END) begin
                        clk_oe_q  <= 1'b0;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= REQUEST;
                    end
                end

                default: begin
                    // Timeout takes priority over any edge arriving in the same cycle
                    if (timeout_d) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        case (state_q)
                            REQUEST: begin
                                if (fall_d) begin
                                    data_oe_q <= ~frame_q[0];
                                    frame_q   <= {1'b0, frame_q[9:1]};
                                    bit_idx_q <= 4'd0;
                                    state_q   <= SHIFT;
                                end
                            end
                            SHIFT: begin
                                if (fall_d) begin
                                    data_oe_q <= ~frame_q[0];
                                    frame_q   <= {1'b0, frame_q[9:1]};
                                    bit_idx_q <= bit_idx_q + 4'd1;
                                    if (bit_idx_q == 4'd8) begin
                                        state_q <= ACK;
                                    end
                                end
                            end
                            ACK: begin
                                if (fall_d) begin
                                    if (!data_sync_q) begin
                                        state_q <= WAIT_RELEASE;
                                    end else begin
                                        error_q <= 1'b1;
                                        state_q <= IDLE;
                                    end
                                end
                            end
                            WAIT_RELEASE: begin
                                if (clk_sync_q && data_sync_q) begin
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end
                            end
                            default: begin
                                clk_oe_q  <= 1'b0;
                                data_oe_q <= 1'b0;
                                state_q   <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
